// File: rtl/sum_accum_pkg.sv
// Shared definitions for the sum accumulator and the adder bench that feeds it.
package sum_accum_pkg;

    localparam int unsigned DEF_IN_W  = 5;
    localparam int unsigned DEF_ACC_W = 12;
    localparam int unsigned CNT_W     = 8;

    // 2'd3 is unused; the FSM treats it as a recovery path back to IDLE.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sum_accumulator_sat_add.sv
// Saturating unsigned adder: acc + zero-extended addend, clamped to all ones on carry-out.
module sat_add #(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [IN_W-1:0]  addend_i,
    output logic [ACC_W-1:0] result_o,
    output logic             carry_o
);

    logic [ACC_W:0] sum;

    assign sum      = {1'b0, acc_i} + (ACC_W+1)'(addend_i);
    assign carry_o  = sum[ACC_W];
    assign result_o = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

endmodule

// File: rtl/sum_accumulator.sv
// Frame accumulator: sums COUNT accepted samples into a saturating total and
// presents it, with a sticky overflow flag, on a valid/ready output handshake.
module sum_accumulator
    import sum_accum_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned ACC_W = DEF_ACC_W,
    parameter int unsigned COUNT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_overflow,
    output logic             busy
);

    localparam logic [CNT_W-1:0] COUNT_C = CNT_W'(COUNT);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             rdy_q;

    logic [ACC_W-1:0] sat_res;
    logic             sat_carry;
    logic             accept;
    logic             out_fire;

    sat_add #(
        .IN_W  (IN_W),
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc_i    (acc_q),
        .addend_i (in_sum),
        .result_o (sat_res),
        .carry_o  (sat_carry)
    );

    // rdy_q keeps in_ready low for the cycle following a reset edge without
    // making in_ready a combinational function of rst_n.
    assign in_ready     = rdy_q && (state_q == IDLE || state_q == ACCUM);
    assign out_valid    = (state_q == DONE);
    assign busy         = (state_q == ACCUM || state_q == DONE);
    assign out_total    = acc_q;
    assign out_overflow = ovf_q;
    assign accept       = in_valid && in_ready;
    assign out_fire     = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        // acc is zero in IDLE, so the adder passes in_sum through.
                        acc_d   = sat_res;
                        ovf_d   = sat_carry;
                        cnt_d   = CNT_W'(1);
                        state_d = (COUNT == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = sat_res;
                        ovf_d = ovf_q | sat_carry;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_d == COUNT_C) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_fire) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            rdy_q   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboard bench for sum_accumulator: default instance plus an ACC_W=8, COUNT=16 saturation instance.
module tb_sum_accumulator;

    typedef struct {
        logic [11:0] tot;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        a_clear, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
    logic [4:0]  a_in_sum;
    logic [11:0] a_out_total;

    logic        b_clear, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
    logic [4:0]  b_in_sum;
    logic [7:0]  b_out_total;

    exp_t qa[$];
    exp_t qb[$];
    int   checks;
    int   errors;

    sum_accumulator #(
        .IN_W  (5),
        .ACC_W (12),
        .COUNT (8)
    ) dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (a_clear),
        .in_valid     (a_in_valid),
        .in_ready     (a_in_ready),
        .in_sum       (a_in_sum),
        .out_valid    (a_out_valid),
        .out_ready    (a_out_ready),
        .out_total    (a_out_total),
        .out_overflow (a_out_ovf),
        .busy         (a_busy)
    );

    sum_accumulator #(
        .IN_W  (5),
        .ACC_W (8),
        .COUNT (16)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (b_clear),
        .in_valid     (b_in_valid),
        .in_ready     (b_in_ready),
        .in_sum       (b_in_sum),
        .out_valid    (b_out_valid),
        .out_ready    (b_out_ready),
        .out_total    (b_out_total),
        .out_overflow (b_out_ovf),
        .busy         (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitors: pop an expected frame result on every output handshake.
    always @(negedge clk) begin
        if (rst_n && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_output", 32'(a_out_total), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("a_total", 32'(a_out_total), 32'(e.tot));
                check("a_ovf", 32'(a_out_ovf), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_output", 32'(b_out_total), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("b_total", 32'(b_out_total), 32'(e.tot));
                check("b_ovf", 32'(b_out_ovf), 32'(e.ovf));
            end
        end
    end

    // All stimulus tasks start and end at posedge+1.
    task automatic send_a(input logic [4:0] v);
        bit done;
        done = 0;
        a_in_valid = 1'b1;
        a_in_sum   = v;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = a_in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("a_send_timeout", 32'd0, 32'd1);
        a_in_valid = 1'b0;
        a_in_sum   = 5'h1b;
    endtask

    task automatic send_b(input logic [4:0] v);
        bit done;
        done = 0;
        b_in_valid = 1'b1;
        b_in_sum   = v;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = b_in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) check("b_send_timeout", 32'd0, 32'd1);
        b_in_valid = 1'b0;
        b_in_sum   = 5'h1b;
    endtask

    task automatic finish_a(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(a_out_valid), 32'd1);
        check({tag, "_in_ready_low"}, 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic finish_b(input string tag);
        @(negedge clk);
        check({tag, "_out_valid"}, 32'(b_out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        a_clear = 1'b0; a_in_valid = 1'b0; a_in_sum = '0; a_out_ready = 1'b1;
        b_clear = 1'b0; b_in_valid = 1'b0; b_in_sum = '0; b_out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_in_ready", 32'(a_in_ready), 32'd0);
        check("rst_out_total", 32'(a_out_total), 32'd0);
        check("rst_out_ovf", 32'(a_out_ovf), 32'd0);
        check("rst_busy", 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic frame: 1..8 = 36, single-cycle out_valid
        qa.push_back('{tot: 12'd36, ovf: 1'b0});
        for (int i = 1; i <= 8; i++) send_a(5'(i));
        finish_a("basic");
        @(negedge clk);
        check("basic_valid_dropped", 32'(a_out_valid), 32'd0);
        check("basic_rearmed", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure: 8 x 31 = 248 held for 5 cycles
        a_out_ready = 1'b0;
        qa.push_back('{tot: 12'd248, ovf: 1'b0});
        for (int i = 0; i < 8; i++) send_a(5'd31);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_out_valid", 32'(a_out_valid), 32'd1);
            check("bp_in_ready", 32'(a_in_ready), 32'd0);
            check("bp_total_held", 32'(a_out_total), 32'd248);
            @(posedge clk);
            #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_idle_in_ready", 32'(a_in_ready), 32'd1);
        check("bp_idle_busy", 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;

        // Gapped input: 8 x 5 = 40 with idle cycles between samples
        qa.push_back('{tot: 12'd40, ovf: 1'b0});
        for (int i = 0; i < 8; i++) begin
            send_a(5'd5);
            if (i < 7) begin
                @(negedge clk);
                check("gap_no_early_valid", 32'(a_out_valid), 32'd0);
                check("gap_partial", 32'(a_out_total), 32'(5 * (i + 1)));
                @(posedge clk);
                #1;
            end
        end
        finish_a("gap");

        // clear mid-frame: partial frame and clear-cycle sample discarded
        for (int i = 0; i < 3; i++) send_a(5'd10);
        a_clear    = 1'b1;
        a_in_valid = 1'b1;
        a_in_sum   = 5'd7;
        @(posedge clk);
        #1;
        a_clear    = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("clr_busy", 32'(a_busy), 32'd0);
        check("clr_total", 32'(a_out_total), 32'd0);
        @(posedge clk);
        #1;
        qa.push_back('{tot: 12'd16, ovf: 1'b0});
        for (int i = 0; i < 8; i++) send_a(5'd2);
        finish_a("clr");

        // Reset while holding DONE
        a_out_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(5'd1);
        @(negedge clk);
        check("rd_out_valid", 32'(a_out_valid), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rd_out_valid_cleared", 32'(a_out_valid), 32'd0);
        check("rd_out_total_cleared", 32'(a_out_total), 32'd0);
        check("rd_busy", 32'(a_busy), 32'd0);
        check("rd_in_ready_low", 32'(a_in_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rd_in_ready_back", 32'(a_in_ready), 32'd1);
        @(posedge clk);
        #1;
        a_out_ready = 1'b1;

        // Saturation on the 8-bit instance, then a clean frame
        qb.push_back('{tot: 12'd255, ovf: 1'b1});
        for (int i = 0; i < 16; i++) send_b(5'd31);
        finish_b("sat");
        qb.push_back('{tot: 12'd16, ovf: 1'b0});
        for (int i = 0; i < 16; i++) send_b(5'd1);
        finish_b("sat_next");

        repeat (2) @(posedge clk);
        #1;
        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
